mem_stream_reader: RTL and testbench



---
 rtl/mem_stream_reader_if.sv | 50 +++++
 rtl/mem_stream_reader.sv | 136 +++++++++++++
 tb/tb_mem_stream_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stream_reader_if.sv
// Signal bundle for mem_stream_reader: command, memory read port, return stream, status.
// stall_cnt_o is present only when MEM_STREAM_READER_PERF_EN is defined.
interface mem_stream_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              cmd_vld_i;
  logic              cmd_rdy_o;
  logic [ADDR_W-1:0] mem_rd_addr_o;
  logic              mem_rd_vld_o;
  logic [DATA_W-1:0] mem_rd_data_i;
  logic              mem_rd_rdy_i;
  logic [DATA_W-1:0] dat_o;
  logic              dat_vld_o;
  logic              dat_last_o;
  logic              dat_rdy_i;
  logic              busy_o;
`ifdef MEM_STREAM_READER_PERF_EN
  logic [15:0]       stall_cnt_o;
`endif

  modport master (
    input  cmd_addr_i, cmd_len_i, cmd_vld_i,
    output cmd_rdy_o,
    output mem_rd_addr_o, mem_rd_vld_o,
    input  mem_rd_data_i, mem_rd_rdy_i,
    output dat_o, dat_vld_o, dat_last_o,
    input  dat_rdy_i,
    output busy_o
`ifdef MEM_STREAM_READER_PERF_EN
    , output stall_cnt_o
`endif
  );

  modport slave (
    output cmd_addr_i, cmd_len_i, cmd_vld_i,
    input  cmd_rdy_o,
    input  mem_rd_addr_o, mem_rd_vld_o,
    output mem_rd_data_i, mem_rd_rdy_i,
    input  dat_o, dat_vld_o, dat_last_o,
    output dat_rdy_i,
    input  busy_o
`ifdef MEM_STREAM_READER_PERF_EN
    , input stall_cnt_o
`endif
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Burst read initiator: sequential memory reads into a credit-limited FIFO, emitted as a stream.
// Optional stall counter enabled by MEM_STREAM_READER_PERF_EN.
module mem_stream_reader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_stream_reader_if.master  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0]  r_issue_rem;
  logic [LEN_W-1:0]  r_beat_len;
  logic [LEN_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  r_reserved;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic [PTR_W-1:0]  r_wr_idx;
  logic [PTR_W-1:0]  r_rd_idx;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic              r_mem_vld;
  logic [ADDR_W-1:0] r_mem_addr;

  logic w_accept, w_issue, w_push, w_pop, w_vld, w_last, w_cmd_rdy, w_busy;

  assign w_vld  = (r_fifo_cnt != '0);
  assign w_last = w_vld && (r_out_cnt == r_beat_len);
  assign w_pop  = w_vld && bus.dat_rdy_i;
  // Returns arriving while idle belong to a burst cut short by reset.
  assign w_push = bus.mem_rd_rdy_i && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_rdy   = 1'b0;
    w_busy      = 1'b1;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cmd_rdy = 1'b1;
        w_busy    = 1'b0;
        if (bus.cmd_vld_i) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_reserved < CNT_W'(FIFO_DEPTH)) begin
          w_issue = 1'b1;
          if (r_issue_rem == '0) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_issue_rem <= '0;
      r_beat_len  <= '0;
      r_out_cnt   <= '0;
      r_reserved  <= '0;
      r_fifo_cnt  <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_mem_vld   <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_mem_vld <= w_issue;
      if (w_accept) begin
        r_rd_ptr    <= bus.cmd_addr_i;
        r_issue_rem <= bus.cmd_len_i;
        r_beat_len  <= bus.cmd_len_i;
      end
      if (w_issue) begin
        r_mem_addr  <= r_rd_ptr;
        r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
        r_issue_rem <= r_issue_rem - LEN_W'(1);
      end
      if (w_accept)   r_out_cnt <= '0;
      else if (w_pop) r_out_cnt <= r_out_cnt + LEN_W'(1);
      if (w_issue && !w_pop)      r_reserved <= r_reserved + CNT_W'(1);
      else if (!w_issue && w_pop) r_reserved <= r_reserved - CNT_W'(1);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
      if (w_push) r_wr_idx <= r_wr_idx + PTR_W'(1);
      if (w_pop)  r_rd_idx <= r_rd_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_idx] <= bus.mem_rd_data_i;
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_fifo_cnt == CNT_W'(FIFO_DEPTH))));

`ifdef MEM_STREAM_READER_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_stall_cnt <= '0;
    else if (w_accept)           r_stall_cnt <= '0;
    else if (w_vld && !bus.dat_rdy_i && (r_stall_cnt != '1))
                                 r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`endif

  assign bus.cmd_rdy_o     = w_cmd_rdy;
  assign bus.busy_o        = w_busy;
  assign bus.mem_rd_vld_o  = r_mem_vld;
  assign bus.mem_rd_addr_o = r_mem_addr;
  assign bus.dat_vld_o     = w_vld;
  assign bus.dat_o         = r_fifo[r_rd_idx];
  assign bus.dat_last_o    = w_last;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a 1-cycle-latency memory model.
module tb_mem_stream_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stream_reader_if #(.DATA_W(8), .ADDR_W(8), .LEN_W(8)) bus ();

  mem_stream_reader #(.DATA_W(8), .ADDR_W(8), .LEN_W(8), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic       mrdy = 1'b0;
  logic [7:0] mdat = 8'h00;

  always @(posedge clk) begin
    mrdy <= bus.mem_rd_vld_o;
    mdat <= mem[bus.mem_rd_addr_o];
  end
  assign bus.mem_rd_rdy_i  = mrdy;
  assign bus.mem_rd_data_i = mdat;

  int         n_rd = 0;
  logic [7:0] rd_addrs[$];
  always @(negedge clk) begin
    if (bus.mem_rd_vld_o) begin
      n_rd++;
      rd_addrs.push_back(bus.mem_rd_addr_o);
    end
  end

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] got[$];
  logic       got_last[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle 0 (command taken).
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
    bus.cmd_addr_i = a;
    bus.cmd_len_i  = l;
    bus.cmd_vld_i  = 1'b1;
    check("cmd_rdy_idle", bus.cmd_rdy_o, 1);
    @(negedge clk);
    bus.cmd_vld_i  = 1'b0;
  endtask

  // Samples from the current negedge on; stops at the last-beat handshake or after max_cyc.
  task automatic collect(input int max_cyc);
    got.delete();
    got_last.delete();
    for (int c = 0; c < max_cyc; c++) begin
      if (bus.dat_vld_o && bus.dat_rdy_i) begin
        got.push_back(bus.dat_o);
        got_last.push_back(bus.dat_last_o);
        if (bus.dat_last_o) return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_beats(input string tag, input logic [7:0] base, input int n);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({tag, "_dat"}, got[i], 8'(base + i));
      check({tag, "_last"}, got_last[i], (i == n - 1));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [7:0] held;
  bit         moved;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5;
    bus.cmd_addr_i = '0;
    bus.cmd_len_i  = '0;
    bus.cmd_vld_i  = 1'b0;
    bus.dat_rdy_i  = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_cmd_rdy", bus.cmd_rdy_o, 1);
    check("rst_rd_vld", bus.mem_rd_vld_o, 0);
    check("rst_dat_vld", bus.dat_vld_o, 0);
    check("rst_dat_last", bus.dat_last_o, 0);
    check("rst_busy", bus.busy_o, 0);
`ifdef MEM_STREAM_READER_PERF_EN
    check("rst_stall", bus.stall_cnt_o, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word
    send_cmd(8'h10, 8'd0);
    check("sw_busy", bus.busy_o, 1);
    check("sw_cmd_rdy", bus.cmd_rdy_o, 0);
    @(negedge clk);
    check("sw_rd_vld", bus.mem_rd_vld_o, 1);
    check("sw_rd_addr", bus.mem_rd_addr_o, 8'h10);
    @(negedge clk);
    check("sw_vld_c2", bus.dat_vld_o, 0);
    @(negedge clk);
    check("sw_vld_c3", bus.dat_vld_o, 1);
    check("sw_dat", bus.dat_o, 8'hA5);
    check("sw_last", bus.dat_last_o, 1);
    @(negedge clk);
    check("sw_cmd_rdy_after", bus.cmd_rdy_o, 1);
    check("sw_vld_after", bus.dat_vld_o, 0);
    check("sw_busy_after", bus.busy_o, 0);

    // Burst without stall: beats in cycles 3..10
    n_rd = 0;
    send_cmd(8'h20, 8'd7);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check("b8_vld", bus.dat_vld_o, (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) begin
        check("b8_dat", bus.dat_o, 8'(8'h20 + c - 3));
        check("b8_last", bus.dat_last_o, (c == 10));
      end
    end
    check("b8_cmd_rdy", bus.cmd_rdy_o, 1);
    check("b8_rd_pulses", n_rd, 8);

    // Address wrap
    n_rd = 0;
    rd_addrs.delete();
    send_cmd(8'hFE, 8'd3);
    collect(20);
    check_beats("wrap", 8'hFE, 4);
    check("wrap_rd_pulses", n_rd, 4);
    for (int i = 0; i < 4 && i < rd_addrs.size(); i++)
      check("wrap_rd_addr", rd_addrs[i], 8'(8'hFE + i));
    @(negedge clk);

    // Backpressure: 10 stalled cycles (3..12), then release
    n_rd = 0;
    bus.dat_rdy_i = 1'b0;
    send_cmd(8'h50, 8'd15);
    moved = 1'b0;
    held  = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("bp_vld_c3", bus.dat_vld_o, 1);
        check("bp_dat_c3", bus.dat_o, 8'h50);
        check("bp_last_c3", bus.dat_last_o, 0);
        held = bus.dat_o;
      end else if (c > 3 && (bus.dat_o !== held || bus.dat_vld_o !== 1'b1)) begin
        moved = 1'b1;
      end
    end
    check("bp_rd_pulses_held", n_rd, 4);
    check("bp_stable", moved, 0);
    @(negedge clk);
`ifdef MEM_STREAM_READER_PERF_EN
    check("bp_stall_cnt", bus.stall_cnt_o, 10);
`endif
    bus.dat_rdy_i = 1'b1;
    collect(60);
    check_beats("bp", 8'h50, 16);
    @(negedge clk);
    check("bp_rd_pulses_total", n_rd, 16);
    check("bp_idle", bus.busy_o, 0);
`ifdef MEM_STREAM_READER_PERF_EN
    check("bp_stall_cnt_end", bus.stall_cnt_o, 10);
`endif

    // Reset mid-burst with a memory return still in flight
    send_cmd(8'h60, 8'd7);
    repeat (4) @(negedge clk);
    check("mr_vld_before", bus.dat_vld_o, 1);
    rst_n = 1'b0;
    #1;
    check("mr_cmd_rdy", bus.cmd_rdy_o, 1);
    check("mr_rd_vld", bus.mem_rd_vld_o, 0);
    check("mr_dat_vld", bus.dat_vld_o, 0);
    check("mr_dat_last", bus.dat_last_o, 0);
    check("mr_busy", bus.busy_o, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_stale_dropped", bus.dat_vld_o, 0);
    n_rd = 0;
    send_cmd(8'h40, 8'd1);
    collect(20);
    check_beats("mr", 8'h40, 2);
    @(negedge clk);
    check("mr_rd_pulses", n_rd, 2);
    check("mr_vld_end", bus.dat_vld_o, 0);

    // Back-to-back commands with cmd_vld_i held high
    bus.cmd_addr_i = 8'h30;
    bus.cmd_len_i  = 8'd1;
    bus.cmd_vld_i  = 1'b1;
    @(negedge clk);
    bus.cmd_addr_i = 8'h70;
    bus.cmd_len_i  = 8'd0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge clk);
      check("bb_cmd_rdy_low", bus.cmd_rdy_o, 0);
      if (c == 3) begin
        check("bb_dat0", bus.dat_o, 8'h30);
        check("bb_last0", bus.dat_last_o, 0);
      end
      if (c == 4) begin
        check("bb_dat1", bus.dat_o, 8'h31);
        check("bb_last1", bus.dat_last_o, 1);
      end
    end
    @(negedge clk);
    check("bb_cmd_rdy_gap", bus.cmd_rdy_o, 1);
    check("bb_vld_gap", bus.dat_vld_o, 0);
    @(negedge clk);
    bus.cmd_vld_i = 1'b0;
    check("bb_second_taken", bus.cmd_rdy_o, 0);
    check("bb_busy", bus.busy_o, 1);
`ifdef MEM_STREAM_READER_PERF_EN
    check("bb_stall_cleared", bus.stall_cnt_o, 0);
`endif
    repeat (3) @(negedge clk);
    check("bb_vld2", bus.dat_vld_o, 1);
    check("bb_dat2", bus.dat_o, 8'h70);
    check("bb_last2", bus.dat_last_o, 1);
    @(negedge clk);
    check("bb_idle", bus.busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
